// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and oversampling constants.
// Used by both the receiver and the transmitter.
package uart_pkg;

    localparam int OVERSAMPLE   = 16;  // s_tick pulses per bit time
    localparam int MID_SAMPLE   = 7;   // tick index at the centre of the start bit
    localparam int DBIT_DEFAULT = 8;   // default data bits per frame

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous single-bit inputs.
// RESET_VAL sets the value both stages take in reset (idle level of the line).
module sync_2ff #(
    parameter int          WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic meta_reg;
            logic sync_reg;

            // Two back-to-back flops per bit to settle metastability.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    meta_reg <= RESET_VAL[gi];
                    sync_reg <= RESET_VAL[gi];
                end else begin
                    meta_reg <= d[gi];
                    sync_reg <= meta_reg;
                end
            end

            assign q[gi] = sync_reg;
        end
    endgenerate

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, LSB first, 1 start bit, DBIT data bits, stop bit
// of SB_TICK ticks. Optional parity checking is enabled with `define UART_RX_PARITY_EN,
// which adds a PARITY state, the PARITY_ODD parameter and the parity_err port.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DBIT       = DBIT_DEFAULT,
    parameter int SB_TICK    = 16
`ifdef UART_RX_PARITY_EN
    ,
    parameter int PARITY_ODD = 0
`endif
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            rx,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err
`ifdef UART_RX_PARITY_EN
    ,
    output logic            parity_err
`endif
);

    // Tick counter must reach both 15 (bit time) and SB_TICK-1 (stop length).
    localparam int SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [SW-1:0] S_MID  = SW'(MID_SAMPLE);
    localparam logic [SW-1:0] S_BIT  = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

    logic rx_s;

    uart_state_t     state_reg, state_next;
    logic [SW-1:0]   s_cnt_reg, s_cnt_next;
    logic [NW-1:0]   n_cnt_reg, n_cnt_next;
    logic [DBIT-1:0] shreg_reg, shreg_next;
    logic [DBIT-1:0] dout_reg, dout_next;
    logic            done_reg, done_next;
    logic            ferr_reg, ferr_next;
`ifdef UART_RX_PARITY_EN
    logic            par_reg, par_next;
    logic            perr_reg, perr_next;
`endif

    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_sync_rx (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            s_cnt_reg <= '0;
            n_cnt_reg <= '0;
            shreg_reg <= '0;
            dout_reg  <= '0;
            done_reg  <= 1'b0;
            ferr_reg  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_reg   <= 1'b0;
            perr_reg  <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            s_cnt_reg <= s_cnt_next;
            n_cnt_reg <= n_cnt_next;
            shreg_reg <= shreg_next;
            dout_reg  <= dout_next;
            done_reg  <= done_next;
            ferr_reg  <= ferr_next;
`ifdef UART_RX_PARITY_EN
            par_reg   <= par_next;
            perr_reg  <= perr_next;
`endif
        end
    end

    // Next-state logic; counters only move on s_tick, except the start-edge detect.
    always_comb begin
        state_next = state_reg;
        s_cnt_next = s_cnt_reg;
        n_cnt_next = n_cnt_reg;
        shreg_next = shreg_reg;
        dout_next  = dout_reg;
        done_next  = 1'b0;
        ferr_next  = ferr_reg;
`ifdef UART_RX_PARITY_EN
        par_next   = par_reg;
        perr_next  = perr_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    s_cnt_next = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_cnt_reg == S_MID) begin
                        if (!rx_s) begin
                            state_next = DATA;
                            s_cnt_next = '0;
                            n_cnt_next = '0;
                        end else begin
                            // Line went back high before the centre: a glitch.
                            state_next = IDLE;
                        end
                    end else begin
                        s_cnt_next = s_cnt_reg + SW'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_cnt_reg == S_BIT) begin
                        shreg_next = {rx_s, shreg_reg[DBIT-1:1]};
                        s_cnt_next = '0;
                        if (n_cnt_reg == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_next = PARITY;
`else
                            state_next = STOP;
`endif
                        end else begin
                            n_cnt_next = n_cnt_reg + NW'(1);
                        end
                    end else begin
                        s_cnt_next = s_cnt_reg + SW'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (s_tick) begin
                    if (s_cnt_reg == S_BIT) begin
                        par_next   = rx_s;
                        s_cnt_next = '0;
                        state_next = STOP;
                    end else begin
                        s_cnt_next = s_cnt_reg + SW'(1);
                    end
                end
            end
`endif
            STOP: begin
                if (s_tick) begin
                    if (s_cnt_reg == S_STOP) begin
                        dout_next  = shreg_reg;
                        ferr_next  = ~rx_s;
`ifdef UART_RX_PARITY_EN
                        perr_next  = ((^shreg_reg) ^ par_reg) != 1'(PARITY_ODD);
`endif
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        s_cnt_next = s_cnt_reg + SW'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign dout         = dout_reg;
    assign rx_done_tick = done_reg;
    assign frame_err    = ferr_reg;
`ifdef UART_RX_PARITY_EN
    assign parity_err   = perr_reg;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: table of frames driven onto rx, expected results queued on
// send and compared when rx_done_tick fires; plus glitch and mid-frame reset sequences.
module tb_uart_rx;

    localparam int TICK_DIV = 4;               // clk cycles per s_tick
    localparam int BIT_CLKS = 16 * TICK_DIV;   // clk cycles per bit time

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       s_tick = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] dout;
    logic       rx_done_tick;
    logic       frame_err;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [7:0] dout;
        logic       ferr;
        logic       perr;
    } exp_t;

    exp_t exp_q[$];

    typedef struct {
        logic [7:0] data;
        logic       stop_ok;
        int         gap_bits;
        logic [7:0] exp_dout;
        logic       exp_ferr;
    } vec_t;

    vec_t tbl[6];

    uart_rx #(
        .DBIT    (8),
        .SB_TICK (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .s_tick       (s_tick),
        .rx           (rx),
        .dout         (dout),
        .rx_done_tick (rx_done_tick),
        .frame_err    (frame_err)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err   (parity_err)
`endif
    );

    always #5 clk = ~clk;

    // Baud-tick generator: one-clk pulse every TICK_DIV clocks.
    int tick_cnt = 0;
    always @(posedge clk) begin
        tick_cnt <= (tick_cnt == TICK_DIV - 1) ? 0 : tick_cnt + 1;
        s_tick   <= (tick_cnt == TICK_DIV - 1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one frame; par_flip inverts the (even) parity bit when parity is built in.
    task automatic send_frame(input logic [7:0] data, input logic stop_ok,
                              input int gap_bits, input logic par_flip);
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            wait_clks(BIT_CLKS);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^data) ^ par_flip;
        wait_clks(BIT_CLKS);
`else
        if (par_flip) rx = 1'b1;
`endif
        if (stop_ok) begin
            rx = 1'b1;
            wait_clks(BIT_CLKS);
        end else begin
            // Low across the stop sample point, then back high well before a restart check.
            rx = 1'b0;
            wait_clks(12 * TICK_DIV);
            rx = 1'b1;
            wait_clks(4 * TICK_DIV);
        end
        wait_clks(gap_bits * BIT_CLKS);
    endtask

    // Scoreboard: each done pulse pops one expected frame.
    logic done_prev = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            done_prev = 1'b0;
        end else begin
            if (rx_done_tick) begin
                check("done_pulse_width", 32'(done_prev), 32'd0);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done actual dout=%02h required=no done", dout);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    $display("rx frame: dout=%02h frame_err=%0b (expected %02h/%0b)",
                             dout, frame_err, e.dout, e.ferr);
                    check("done_dout", 32'(dout), 32'(e.dout));
                    check("done_frame_err", 32'(frame_err), 32'(e.ferr));
`ifdef UART_RX_PARITY_EN
                    check("done_parity_err", 32'(parity_err), 32'(e.perr));
`endif
                end
            end
            done_prev = rx_done_tick;
        end
    end

    initial begin
        exp_t e;
        logic [7:0] held_dout;
        logic       held_ferr;

        tbl[0] = '{8'hA5, 1'b1, 1, 8'hA5, 1'b0};
        tbl[1] = '{8'h00, 1'b1, 0, 8'h00, 1'b0};  // back-to-back with next
        tbl[2] = '{8'hFF, 1'b1, 1, 8'hFF, 1'b0};
        tbl[3] = '{8'h01, 1'b1, 0, 8'h01, 1'b0};
        tbl[4] = '{8'h80, 1'b1, 1, 8'h80, 1'b0};
        tbl[5] = '{8'h3C, 1'b0, 2, 8'h3C, 1'b1};  // stop bit forced low

        // Reset state
        wait_clks(5);
        check("reset_dout", 32'(dout), 32'd0);
        check("reset_done", 32'(rx_done_tick), 32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        reset = 1'b0;
        wait_clks(BIT_CLKS);

        for (int i = 0; i < 6; i++) begin
            e.dout = tbl[i].exp_dout;
            e.ferr = tbl[i].exp_ferr;
            e.perr = 1'b0;
            exp_q.push_back(e);
            $display("send frame %0d: data=%02h stop_ok=%0b gap=%0d",
                     i, tbl[i].data, tbl[i].stop_ok, tbl[i].gap_bits);
            send_frame(tbl[i].data, tbl[i].stop_ok, tbl[i].gap_bits, 1'b0);
        end
        check("table_all_frames_done", 32'(exp_q.size()), 32'd0);

        // Short low glitch: must be rejected, outputs held.
        held_dout = tbl[5].exp_dout;
        held_ferr = tbl[5].exp_ferr;
        $display("send glitch: rx low for 4 ticks");
        rx = 1'b0;
        wait_clks(4 * TICK_DIV);
        rx = 1'b1;
        wait_clks(3 * BIT_CLKS);
        check("glitch_dout_held", 32'(dout), 32'(held_dout));
        check("glitch_ferr_held", 32'(frame_err), 32'(held_ferr));

        // Reset in the middle of data bit 4 of 0x81: frame discarded.
        $display("send 0x81 with reset during data bit 4");
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 4; i++) begin
            rx = (i == 0);
            wait_clks(BIT_CLKS);
        end
        rx = 1'b0;
        wait_clks(BIT_CLKS / 2);
        reset = 1'b1;
        rx = 1'b1;
        #1;
        check("midreset_dout", 32'(dout), 32'd0);
        check("midreset_frame_err", 32'(frame_err), 32'd0);
        check("midreset_done", 32'(rx_done_tick), 32'd0);
        wait_clks(3);
        reset = 1'b0;
        wait_clks(2 * BIT_CLKS);

        e.dout = 8'h55; e.ferr = 1'b0; e.perr = 1'b0;
        exp_q.push_back(e);
        $display("send frame: data=55 after reset");
        send_frame(8'h55, 1'b1, 1, 1'b0);

`ifdef UART_RX_PARITY_EN
        e.dout = 8'h07; e.ferr = 1'b0; e.perr = 1'b1;
        exp_q.push_back(e);
        $display("send frame: data=07 parity bit 0");
        send_frame(8'h07, 1'b1, 1, 1'b1);
        e.dout = 8'h07; e.ferr = 1'b0; e.perr = 1'b0;
        exp_q.push_back(e);
        $display("send frame: data=07 parity bit 1");
        send_frame(8'h07, 1'b1, 1, 1'b0);
`endif

        wait_clks(BIT_CLKS);
        check("final_all_frames_done", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
